// File: rtl/touch_packet_rx.sv
// touch_packet_rx: UART receiver and 5-byte report framer for the resistive
// touchscreen controller. Decodes header/X/Y reports into one touch event
// and presents it on a valid/ready interface with single-entry buffering.
module touch_packet_rx #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        touch_valid,
    input  logic        touch_ready,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic        touch_pen,
    output logic        framing_err,
    output logic        sync_err,
    output logic        overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMO_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W        = $clog2(TMO_CLKS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        FR_HDR,
        FR_XL,
        FR_XH,
        FR_YL,
        FR_YH
    } fr_state_t;

    // Line synchronizer
    logic rxd_meta_q;
    logic rxd_sync_q;

    // Receiver state
    rx_state_t        rx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_stb_q;
    logic             framing_err_q;

    // Framer state
    fr_state_t        fr_q;
    logic [TMO_W-1:0] tmo_q;
    logic             pen_pend_q;
    logic [6:0]       x_lo_q;
    logic [4:0]       x_hi_q;
    logic [6:0]       y_lo_q;
    logic             sync_err_q;
    logic             overrun_q;
    logic             touch_valid_q;
    logic [11:0]      touch_x_q;
    logic [11:0]      touch_y_q;
    logic             touch_pen_q;

    logic is_hdr;
    logic is_data;

    assign is_hdr  = shift_q[7] && (shift_q[6:1] == '0);
    assign is_data = !shift_q[7];

    // Two-flop synchronizer for the asynchronous UART line, idling high
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // 8N1 receiver: mid-bit sampling, byte strobe or framing error at stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q          <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_stb_q    <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            byte_stb_q    <= 1'b0;
            framing_err_q <= 1'b0;
            case (rx_q)
                RX_IDLE: begin
                    if (!rxd_sync_q) begin
                        cnt_q <= CNT_HALF;
                        rx_q  <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rxd_sync_q) begin
                        rx_q <= RX_IDLE;
                    end else begin
                        cnt_q     <= CNT_FULL;
                        bit_idx_q <= '0;
                        rx_q      <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rxd_sync_q, shift_q[7:1]};
                        cnt_q   <= CNT_FULL;
                        if (bit_idx_q == 3'd7) begin
                            rx_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rxd_sync_q) begin
                        byte_stb_q <= 1'b1;
                        rx_q       <= RX_IDLE;
                    end else begin
                        framing_err_q <= 1'b1;
                        rx_q          <= RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    if (rxd_sync_q) begin
                        rx_q <= RX_IDLE;
                    end
                end
                default: rx_q <= RX_IDLE;
            endcase
        end
    end

    // Packet framer, inter-byte timeout and single-entry output register
    always_ff @(posedge clk) begin
        if (reset) begin
            fr_q          <= FR_HDR;
            tmo_q         <= '0;
            pen_pend_q    <= 1'b0;
            x_lo_q        <= '0;
            x_hi_q        <= '0;
            y_lo_q        <= '0;
            sync_err_q    <= 1'b0;
            overrun_q     <= 1'b0;
            touch_valid_q <= 1'b0;
            touch_x_q     <= '0;
            touch_y_q     <= '0;
            touch_pen_q   <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            // A completion later in this block overrides the handshake clear,
            // so a same-cycle accept-and-load keeps touch_valid high.
            if (touch_valid_q && touch_ready) begin
                touch_valid_q <= 1'b0;
            end
            if (framing_err_q) begin
                fr_q  <= FR_HDR;
                tmo_q <= '0;
            end else if (byte_stb_q) begin
                tmo_q <= '0;
                if (fr_q == FR_HDR) begin
                    if (is_hdr) begin
                        pen_pend_q <= shift_q[0];
                        fr_q       <= FR_XL;
                    end else begin
                        sync_err_q <= 1'b1;
                    end
                end else if (is_data) begin
                    case (fr_q)
                        FR_XL: begin
                            x_lo_q <= shift_q[6:0];
                            fr_q   <= FR_XH;
                        end
                        FR_XH: begin
                            x_hi_q <= shift_q[4:0];
                            fr_q   <= FR_YL;
                        end
                        FR_YL: begin
                            y_lo_q <= shift_q[6:0];
                            fr_q   <= FR_YH;
                        end
                        FR_YH: begin
                            touch_x_q     <= {x_hi_q, x_lo_q};
                            touch_y_q     <= {shift_q[4:0], y_lo_q};
                            touch_pen_q   <= pen_pend_q;
                            touch_valid_q <= 1'b1;
                            overrun_q     <= touch_valid_q && !touch_ready;
                            fr_q          <= FR_HDR;
                        end
                        default: fr_q <= FR_HDR;
                    endcase
                end else begin
                    sync_err_q <= 1'b1;
                    if (is_hdr) begin
                        pen_pend_q <= shift_q[0];
                        fr_q       <= FR_XL;
                    end else begin
                        fr_q <= FR_HDR;
                    end
                end
            end else if (fr_q != FR_HDR && rx_q == RX_IDLE) begin
                if (tmo_q == TMO_LAST) begin
                    sync_err_q <= 1'b1;
                    fr_q       <= FR_HDR;
                    tmo_q      <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign touch_valid = touch_valid_q;
    assign touch_x     = touch_x_q;
    assign touch_y     = touch_y_q;
    assign touch_pen   = touch_pen_q;
    assign framing_err = framing_err_q;
    assign sync_err    = sync_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_touch_packet_rx.sv
// Testbench for touch_packet_rx: table of packet scenarios plus hand-written
// sequences for reset, overrun/handshake, timeout and mid-packet reset.
module tb_touch_packet_rx;

    localparam int unsigned CPB = 10;

    logic        clk;
    logic        reset;
    logic        rxd;
    logic        touch_valid;
    logic        touch_ready;
    logic [11:0] touch_x;
    logic [11:0] touch_y;
    logic        touch_pen;
    logic        framing_err;
    logic        sync_err;
    logic        overrun;

    touch_packet_rx #(
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000),
        .TIMEOUT_BITS(40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .touch_valid(touch_valid),
        .touch_ready(touch_ready),
        .touch_x    (touch_x),
        .touch_y    (touch_y),
        .touch_pen  (touch_pen),
        .framing_err(framing_err),
        .sync_err   (sync_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event and pulse counters, sampled on the falling edge
    int unsigned n_sync, n_ferr, n_ovr, n_vcyc, n_ev;
    int unsigned b_sync, b_ferr, b_ovr, b_vcyc, b_ev;
    logic [11:0] ev_x, ev_y;
    logic        ev_pen;

    initial begin
        n_sync = 0; n_ferr = 0; n_ovr = 0; n_vcyc = 0; n_ev = 0;
        ev_x = '0; ev_y = '0; ev_pen = 1'b0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (sync_err)    n_sync++;
            if (framing_err) n_ferr++;
            if (overrun)     n_ovr++;
            if (touch_valid) n_vcyc++;
            if (touch_valid && touch_ready) begin
                n_ev++;
                ev_x   = touch_x;
                ev_y   = touch_y;
                ev_pen = touch_pen;
            end
        end
    end

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic mark();
        b_sync = n_sync; b_ferr = n_ferr; b_ovr = n_ovr; b_vcyc = n_vcyc; b_ev = n_ev;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        idle(CPB);
        for (int unsigned k = 0; k < 8; k++) begin
            rxd = b[k];
            idle(CPB);
        end
        rxd = stop_ok;
        idle(CPB);
        rxd = 1'b1;
        if (!stop_ok) idle(2 * CPB);
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] xl, input logic [7:0] xh,
                            input logic [7:0] yl, input logic [7:0] yh);
        send_byte(h, 1'b1);
        send_byte(xl, 1'b1);
        send_byte(xh, 1'b1);
        send_byte(yl, 1'b1);
        send_byte(yh, 1'b1);
    endtask

    typedef struct {
        int unsigned nb;
        logic [7:0]  b [8];
        logic [7:0]  badstop;
        int unsigned ev;
        logic [11:0] x;
        logic [11:0] y;
        logic        pen;
        int unsigned se;
        int unsigned fe;
    } vec_t;

    vec_t vecs [7];

    initial begin
        reset       = 1'b1;
        rxd         = 1'b1;
        touch_ready = 1'b0;

        vecs[0] = '{nb: 5, b: '{8'h81, 8'h34, 8'h12, 8'h05, 8'h0A, 8'h00, 8'h00, 8'h00},
                    badstop: 8'h00, ev: 1, x: 12'h934, y: 12'h505, pen: 1'b1, se: 0, fe: 0};
        vecs[1] = '{nb: 7, b: '{8'h81, 8'h34, 8'h80, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00},
                    badstop: 8'h00, ev: 1, x: 12'h001, y: 12'h002, pen: 1'b0, se: 1, fe: 0};
        vecs[2] = '{nb: 6, b: '{8'h81, 8'h81, 8'h34, 8'h12, 8'h05, 8'h0A, 8'h00, 8'h00},
                    badstop: 8'h01, ev: 1, x: 12'h934, y: 12'h505, pen: 1'b1, se: 0, fe: 1};
        vecs[3] = '{nb: 5, b: '{8'h80, 8'h7F, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    badstop: 8'h00, ev: 1, x: 12'hFFF, y: 12'h000, pen: 1'b0, se: 0, fe: 0};
        vecs[4] = '{nb: 5, b: '{8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h60, 8'h00, 8'h00, 8'h00},
                    badstop: 8'h00, ev: 1, x: 12'hFFF, y: 12'h07F, pen: 1'b0, se: 0, fe: 0};
        vecs[5] = '{nb: 7, b: '{8'h55, 8'h83, 8'h81, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00},
                    badstop: 8'h00, ev: 1, x: 12'h001, y: 12'h001, pen: 1'b1, se: 2, fe: 0};
        vecs[6] = '{nb: 8, b: '{8'h81, 8'h34, 8'hC0, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00},
                    badstop: 8'h00, ev: 1, x: 12'h000, y: 12'h000, pen: 1'b1, se: 1, fe: 0};

        // Reset and quiet line
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset valid", 32'(touch_valid), 0);
        check("reset x", 32'(touch_x), 0);
        check("reset y", 32'(touch_y), 0);
        check("reset pen", 32'(touch_pen), 0);
        check("reset pulses", 32'({framing_err, sync_err, overrun}), 0);
        tick();
        mark();
        idle(100);
        check("idle pulses", n_sync - b_sync + n_ferr - b_ferr + n_ovr - b_ovr + n_vcyc - b_vcyc, 0);

        // Table-driven packet scenarios with the consumer always ready
        touch_ready = 1'b1;
        for (int unsigned i = 0; i < 7; i++) begin
            mark();
            for (int unsigned j = 0; j < vecs[i].nb; j++) begin
                send_byte(vecs[i].b[j], !vecs[i].badstop[j]);
            end
            idle(30);
            check($sformatf("v%0d events", i), n_ev - b_ev, vecs[i].ev);
            check($sformatf("v%0d valid cycles", i), n_vcyc - b_vcyc, vecs[i].ev);
            check($sformatf("v%0d sync_err", i), n_sync - b_sync, vecs[i].se);
            check($sformatf("v%0d framing_err", i), n_ferr - b_ferr, vecs[i].fe);
            check($sformatf("v%0d overrun", i), n_ovr - b_ovr, 0);
            if (vecs[i].ev != 0) begin
                check($sformatf("v%0d x", i), 32'(ev_x), 32'(vecs[i].x));
                check($sformatf("v%0d y", i), 32'(ev_y), 32'(vecs[i].y));
                check($sformatf("v%0d pen", i), 32'(ev_pen), 32'(vecs[i].pen));
            end
        end

        // Overrun: newest event wins, then handshake drops valid next cycle
        touch_ready = 1'b0;
        mark();
        send_pkt(8'h81, 8'h34, 8'h12, 8'h05, 8'h0A);
        idle(20);
        check("ovr first valid", 32'(touch_valid), 1);
        check("ovr first x", 32'(touch_x), 12'h934);
        idle(30);
        check("ovr held x", 32'(touch_x), 12'h934);
        send_pkt(8'h81, 8'h00, 8'h02, 8'h05, 8'h0A);
        idle(20);
        check("ovr pulses", n_ovr - b_ovr, 1);
        check("ovr valid", 32'(touch_valid), 1);
        check("ovr x", 32'(touch_x), 12'h100);
        check("ovr y", 32'(touch_y), 12'h505);
        check("ovr pen", 32'(touch_pen), 1);
        touch_ready = 1'b1;
        @(negedge clk);
        check("ovr valid before accept", 32'(touch_valid), 1);
        @(posedge clk);
        #1;
        check("ovr valid after accept", 32'(touch_valid), 0);
        check("ovr accepted", n_ev - b_ev, 1);
        check("ovr accepted x", 32'(ev_x), 12'h100);

        // Inter-byte timeout, then orphan data bytes
        idle(20);
        mark();
        send_byte(8'h81, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(38 * CPB);
        check("tmo not early", n_sync - b_sync, 0);
        idle(3 * CPB);
        check("tmo fired", n_sync - b_sync, 1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h0A, 1'b1);
        idle(30);
        check("tmo sync total", n_sync - b_sync, 4);
        check("tmo no event", n_vcyc - b_vcyc, 0);

        // Reset mid-packet while holding an event
        touch_ready = 1'b0;
        send_pkt(8'h81, 8'h34, 8'h12, 8'h05, 8'h0A);
        idle(20);
        check("rst held valid", 32'(touch_valid), 1);
        send_byte(8'h81, 1'b1);
        send_byte(8'h34, 1'b1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst valid lost", 32'(touch_valid), 0);
        check("rst x cleared", 32'(touch_x), 0);
        touch_ready = 1'b1;
        tick();
        mark();
        send_byte(8'h12, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h0A, 1'b1);
        idle(30);
        check("rst partial dropped", n_sync - b_sync, 3);
        check("rst no event", n_vcyc - b_vcyc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
